// File: rtl/xbar_pkg.sv
// Shared crossbar types and the address-to-slave decode helper.
package xbar_pkg;

  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;

  typedef enum logic [BURST_W-1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  // Decode result: dest is wide enough for any realistic slave count and is
  // narrowed by the caller to its own DEST_W.
  typedef struct packed {
    logic        err;
    logic [15:0] dest;
  } decode_t;

  // Out-of-range addresses are steered to the last slave (default/error slave).
  function automatic int unsigned default_slave(input int unsigned slaves);
    return slaves - 1;
  endfunction

  function automatic decode_t slave_decode(input logic [15:0] idx,
                                           input int unsigned slaves);
    decode_t d;
    d.err  = 1'b0;
    d.dest = idx;
    if ({16'd0, idx} >= slaves) begin
      d.err  = 1'b1;
      d.dest = 16'(default_slave(slaves));
    end
    return d;
  endfunction

endpackage

// File: rtl/master_addr_ingress_if.sv
// AXI address-channel (AW or AR) handshake and payload from one master.
interface master_addr_ingress_if
  import xbar_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned LEN_W  = 8
);
  logic              s_avalid;
  logic              s_aready;
  logic [ID_W-1:0]   s_aid;
  logic [ADDR_W-1:0] s_aaddr;
  logic [LEN_W-1:0]  s_alen;
  logic [SIZE_W-1:0] s_asize;
  burst_t            s_aburst;

  modport master (output s_avalid, s_aid, s_aaddr, s_alen, s_asize, s_aburst,
                  input  s_aready);
  modport slave  (input  s_avalid, s_aid, s_aaddr, s_alen, s_asize, s_aburst,
                  output s_aready);
endinterface

// File: rtl/master_addr_ingress_sync_fifo.sv
// Generic synchronous FIFO; full/empty come from the occupancy counter.
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage write; cleared on reset so the head reads zero until the first push.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; occupancy tracks net change.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_occ_bound: assert property (@(posedge ACLK) disable iff (!ARESETn)
    r_count <= CNT_W'(DEPTH));

endmodule

// File: rtl/master_addr_ingress.sv
// Per-master ingress: decode target slave, buffer requests, expose FIFO head to arbiters.
module master_addr_ingress
  import xbar_pkg::*;
#(
  parameter  int unsigned SLAVES = 2,
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned ID_W   = 4,
  parameter  int unsigned LEN_W  = 8,
  localparam int unsigned DEST_W = $clog2(SLAVES),
  localparam int unsigned OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  master_addr_ingress_if.slave mst,
  output logic                fifo_empty,
  output logic [DEST_W-1:0]   head_dest,
  output logic [ID_W-1:0]     head_id,
  output logic [ADDR_W-1:0]   head_addr,
  output logic [LEN_W-1:0]    head_len,
  output logic [SIZE_W-1:0]   head_size,
  output logic [1:0]          head_burst,
  input  logic                pop,
  output logic [OCC_W-1:0]    occupancy,
  output logic                decode_err
);
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [SIZE_W-1:0] size;
    burst_t            burst;
  } addr_req_t;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    addr_req_t         req;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  logic [DEST_W-1:0]  w_idx;
  decode_t            w_dec;
  entry_t             w_wentry;
  entry_t             w_head;
  logic [ENTRY_W-1:0] w_rdata;
  logic               w_full;
  logic               w_push;
  logic               r_decode_err;

  assign w_idx = mst.s_aaddr[ADDR_W-1 -: DEST_W];
  assign w_dec = slave_decode(16'(w_idx), SLAVES);

  assign w_wentry.dest      = DEST_W'(w_dec.dest);
  assign w_wentry.req.id    = mst.s_aid;
  assign w_wentry.req.addr  = mst.s_aaddr;
  assign w_wentry.req.len   = mst.s_alen;
  assign w_wentry.req.size  = mst.s_asize;
  assign w_wentry.req.burst = mst.s_aburst;

  // Ready depends only on registered occupancy, never on valid or pop.
  assign mst.s_aready = ~w_full;
  assign w_push       = mst.s_avalid & mst.s_aready;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .i_push  (w_push),
    .i_pop   (pop),
    .i_wdata (w_wentry),
    .o_rdata (w_rdata),
    .o_empty (fifo_empty),
    .o_full  (w_full),
    .o_count (occupancy)
  );

  assign w_head     = w_rdata;
  assign head_dest  = w_head.dest;
  assign head_id    = w_head.req.id;
  assign head_addr  = w_head.req.addr;
  assign head_len   = w_head.req.len;
  assign head_size  = w_head.req.size;
  assign head_burst = w_head.req.burst;
  assign decode_err = r_decode_err;

  // Sticky flag: any accepted out-of-range address latches until reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETn)                r_decode_err <= 1'b0;
    else if (w_push & w_dec.err) r_decode_err <= 1'b1;
  end

  a_axi_hold: assert property (@(posedge ACLK) disable iff (!ARESETn)
    (mst.s_avalid && !mst.s_aready) |=>
      (mst.s_avalid && $stable({mst.s_aid, mst.s_aaddr, mst.s_alen, mst.s_asize, mst.s_aburst})));

endmodule

// File: tb/tb_master_addr_ingress.sv
module tb_master_addr_ingress;
  import xbar_pkg::*;

  logic ACLK = 1'b0;
  logic ARESETn;
  always #5 ACLK = ~ACLK;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // DUT A: SLAVES=2, DEPTH=4
  master_addr_ingress_if #(.ADDR_W(32), .ID_W(4), .LEN_W(8)) ifa ();
  logic        a_empty, a_pop, a_err;
  logic [0:0]  a_dest;
  logic [3:0]  a_id;
  logic [31:0] a_addr;
  logic [7:0]  a_len;
  logic [2:0]  a_size;
  logic [1:0]  a_burst;
  logic [2:0]  a_occ;

  master_addr_ingress #(.SLAVES(2), .DEPTH(4), .ADDR_W(32), .ID_W(4), .LEN_W(8)) u_dut_a (
    .ACLK(ACLK), .ARESETn(ARESETn), .mst(ifa.slave),
    .fifo_empty(a_empty), .head_dest(a_dest), .head_id(a_id), .head_addr(a_addr),
    .head_len(a_len), .head_size(a_size), .head_burst(a_burst),
    .pop(a_pop), .occupancy(a_occ), .decode_err(a_err)
  );

  // DUT B: SLAVES=3 exercises the out-of-range decode
  master_addr_ingress_if #(.ADDR_W(32), .ID_W(4), .LEN_W(8)) ifb ();
  logic        b_empty, b_pop, b_err;
  logic [1:0]  b_dest;
  logic [3:0]  b_id;
  logic [31:0] b_addr;
  logic [7:0]  b_len;
  logic [2:0]  b_size;
  logic [1:0]  b_burst;
  logic [2:0]  b_occ;

  master_addr_ingress #(.SLAVES(3), .DEPTH(4), .ADDR_W(32), .ID_W(4), .LEN_W(8)) u_dut_b (
    .ACLK(ACLK), .ARESETn(ARESETn), .mst(ifb.slave),
    .fifo_empty(b_empty), .head_dest(b_dest), .head_id(b_id), .head_addr(b_addr),
    .head_len(b_len), .head_size(b_size), .head_burst(b_burst),
    .pop(b_pop), .occupancy(b_occ), .decode_err(b_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [3:0] id, input logic [31:0] addr);
    ifa.s_avalid = v;
    ifa.s_aid    = id;
    ifa.s_aaddr  = addr;
    ifa.s_alen   = {4'h0, id};
    ifa.s_asize  = 3'd2;
    ifa.s_aburst = BURST_INCR;
  endtask

  task automatic drive_b(input logic v, input logic [3:0] id, input logic [31:0] addr);
    ifb.s_avalid = v;
    ifb.s_aid    = id;
    ifb.s_aaddr  = addr;
    ifb.s_alen   = 8'h0;
    ifb.s_asize  = 3'd3;
    ifb.s_aburst = BURST_WRAP;
  endtask

  initial begin
    ARESETn = 1'b0;
    a_pop = 1'b0;
    b_pop = 1'b0;
    drive_a(1'b0, 4'h0, 32'h0);
    drive_b(1'b0, 4'h0, 32'h0);
    tick();
    tick();

    // Reset state
    chk("rst_empty", a_empty, 1);
    chk("rst_ready", ifa.s_aready, 1);
    chk("rst_occ", a_occ, 0);
    chk("rst_err", a_err, 0);
    chk("rst_head_id", a_id, 0);
    chk("rst_head_addr", a_addr, 0);
    ARESETn = 1'b1;
    tick();

    // Single push to 0x8000_0000 -> slave 1, visible next cycle
    drive_a(1'b1, 4'h5, 32'h8000_0000);
    tick();
    drive_a(1'b0, 4'h0, 32'h0);
    chk("p1_empty", a_empty, 0);
    chk("p1_dest", a_dest, 1);
    chk("p1_occ", a_occ, 1);
    chk("p1_err", a_err, 0);
    chk("p1_id", a_id, 5);
    chk("p1_addr", a_addr, 32'h8000_0000);
    chk("p1_len", a_len, 5);
    chk("p1_size", a_size, 2);
    chk("p1_burst", a_burst, 2'b01);
    a_pop = 1'b1;
    tick();
    a_pop = 1'b0;
    chk("p1_pop_empty", a_empty, 1);
    chk("p1_pop_occ", a_occ, 0);

    // Fill to DEPTH with IDs 0..3, then hold a 5th request
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 4'(i), 32'(i) << 28);
      tick();
    end
    chk("full_ready", ifa.s_aready, 0);
    chk("full_occ", a_occ, 4);
    chk("full_head", a_id, 0);
    chk("full_dest", a_dest, 0);
    drive_a(1'b1, 4'h4, 32'h4000_0000);
    tick();
    chk("held_ready", ifa.s_aready, 0);
    chk("held_occ", a_occ, 4);
    chk("held_head", a_id, 0);

    // Pop while full with valid held: only the pop happens
    a_pop = 1'b1;
    tick();
    a_pop = 1'b0;
    chk("fpop_occ", a_occ, 3);
    chk("fpop_ready", ifa.s_aready, 1);
    chk("fpop_head", a_id, 1);
    tick();
    drive_a(1'b0, 4'h0, 32'h0);
    chk("held_acc_occ", a_occ, 4);
    chk("held_acc_ready", ifa.s_aready, 0);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("drain_head%0d", k), a_id, 64'(k));
      a_pop = 1'b1;
      tick();
      a_pop = 1'b0;
    end
    chk("drain_empty", a_empty, 1);
    chk("drain_occ", a_occ, 0);

    // Occupancy 2 with simultaneous push/pop; pointers wrap repeatedly
    drive_a(1'b1, 4'h0, 32'h8000_0000);
    tick();
    drive_a(1'b1, 4'h1, 32'h8000_0010);
    tick();
    chk("pp_start_occ", a_occ, 2);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("pp_head%0d", k), a_id, 64'(k));
      drive_a(1'b1, 4'(k + 2), 32'(k + 2));
      a_pop = 1'b1;
      tick();
      chk($sformatf("pp_occ%0d", k), a_occ, 2);
    end
    drive_a(1'b0, 4'h0, 32'h0);
    chk("pp_tail10", a_id, 10);
    tick();
    chk("pp_tail11", a_id, 11);
    chk("pp_tail11_addr", a_addr, 11);
    tick();
    a_pop = 1'b0;
    chk("pp_end_empty", a_empty, 1);

    // SLAVES=3: idx 2 is in range; idx 3 goes to slave 2 with sticky error
    drive_b(1'b1, 4'h3, 32'h8000_0000);
    tick();
    drive_b(1'b0, 4'h0, 32'h0);
    chk("b_inrange_dest", b_dest, 2);
    chk("b_inrange_err", b_err, 0);
    b_pop = 1'b1;
    tick();
    b_pop = 1'b0;
    drive_b(1'b1, 4'h7, 32'hC000_0000);
    tick();
    drive_b(1'b0, 4'h0, 32'h0);
    chk("b_oor_dest", b_dest, 2);
    chk("b_oor_err", b_err, 1);
    chk("b_oor_id", b_id, 7);
    b_pop = 1'b1;
    tick();
    b_pop = 1'b0;
    chk("b_sticky_err", b_err, 1);
    chk("b_sticky_empty", b_empty, 1);
    chk("a_no_err", a_err, 0);

    // Pop while empty is ignored
    a_pop = 1'b1;
    tick();
    a_pop = 1'b0;
    chk("epop_occ", a_occ, 0);
    chk("epop_empty", a_empty, 1);
    drive_a(1'b1, 4'h9, 32'h8000_0000);
    tick();
    drive_a(1'b0, 4'h0, 32'h0);
    chk("epop_then_head", a_id, 9);

    // Reset with 3 entries buffered and pop asserted
    drive_a(1'b1, 4'hA, 32'h0);
    tick();
    drive_a(1'b1, 4'hB, 32'h0);
    tick();
    drive_a(1'b0, 4'h0, 32'h0);
    chk("prerst_occ", a_occ, 3);
    ARESETn = 1'b0;
    a_pop = 1'b1;
    tick();
    ARESETn = 1'b1;
    a_pop = 1'b0;
    chk("mrst_empty", a_empty, 1);
    chk("mrst_occ", a_occ, 0);
    chk("mrst_ready", ifa.s_aready, 1);
    chk("mrst_head", a_id, 0);
    chk("mrst_b_err", b_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
